// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types and constants for the two-port RAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam logic REQ_CORE   = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

    // Clears the byte-offset bits; sliced down to the configured address width.
    localparam logic [63:0] WORD_ADDR_MASK = ~64'h3;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-input round-robin grant with a last-grant register.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
#(
    parameter int CORE_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic       o_valid,
    output logic       o_grant
);

    logic r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Pretend the other side was served last so the preferred side wins first.
            r_last <= (CORE_FIRST != 0) ? REQ_LOADER : REQ_CORE;
        end else if (i_update && o_valid) begin
            r_last <= o_grant;
        end
    end

    always_comb begin
        o_valid = |i_req;
        o_grant = REQ_CORE;
        if (&i_req) begin
            o_grant = ~r_last;
        end else if (i_req[REQ_LOADER]) begin
            o_grant = REQ_LOADER;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares a single-port RAM between the core data port and the
//               loader/debug port with a fixed three-cycle access sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int CORE_FIRST = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              r0_req,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [31:0]       r0_wdata,
    input  logic [3:0]        r0_wmask,
    output logic [31:0]       r0_rdata,
    output logic              r0_ack,
    input  logic              r1_req,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [31:0]       r1_wdata,
    input  logic [3:0]        r1_wmask,
    output logic [31:0]       r1_rdata,
    output logic              r1_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    output logic              mem_rstrb,
    input  logic [31:0]       mem_rdata,
    output logic              oob_err
);

    localparam logic [ADDR_W:0] c_mem_bytes = (ADDR_W+1)'(MEM_WORDS * 4);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              w_grant_en;
    logic              w_arb_valid;
    logic              w_arb_grant;

    logic              r_grant;
    logic              r_is_read;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [3:0]        r_mem_wmask;
    logic              r_mem_rstrb;
    logic              r_oob;
    logic [31:0]       r_r0_rdata;
    logic [31:0]       r_r1_rdata;

    logic [ADDR_W-1:0] w_win_addr;
    logic [ADDR_W-1:0] w_aligned;
    logic [ADDR_W-1:0] w_wrapped;
    logic [31:0]       w_win_wdata;
    logic [3:0]        w_win_wmask;
    logic              w_oob;
    logic              w_resp;

    rr_arbiter2 #(
        .CORE_FIRST (CORE_FIRST)
    ) u_rr (
        .clk      (clk),
        .rst      (reset),
        .i_req    ({r1_req, r0_req}),
        .i_update (w_grant_en),
        .o_valid  (w_arb_valid),
        .o_grant  (w_arb_grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_grant_en  = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_win_addr  = (w_arb_grant == REQ_LOADER) ? r1_addr  : r0_addr;
        w_win_wdata = (w_arb_grant == REQ_LOADER) ? r1_wdata : r0_wdata;
        w_win_wmask = (w_arb_grant == REQ_LOADER) ? r1_wmask : r0_wmask;
        w_aligned   = w_win_addr & WORD_ADDR_MASK[ADDR_W-1:0];
        // Out-of-range accesses still go through, wrapped into the RAM.
        w_oob       = ({1'b0, w_aligned} >= c_mem_bytes);
        w_wrapped   = ADDR_W'({1'b0, w_aligned} % c_mem_bytes);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant     <= REQ_CORE;
            r_is_read   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wmask <= '0;
            r_mem_rstrb <= 1'b0;
            r_oob       <= 1'b0;
            r_r0_rdata  <= '0;
            r_r1_rdata  <= '0;
        end else begin
            if (w_grant_en) begin
                r_grant     <= w_arb_grant;
                r_is_read   <= (w_win_wmask == 4'h0);
                r_mem_addr  <= w_wrapped;
                r_mem_wdata <= w_win_wdata;
                r_mem_wmask <= w_win_wmask;
                r_mem_rstrb <= (w_win_wmask == 4'h0);
                if (w_oob) begin
                    r_oob <= 1'b1;
                end
            end else if (r_state == ST_ACCESS) begin
                r_mem_wmask <= '0;
                r_mem_rstrb <= 1'b0;
            end
            if ((r_state == ST_RESP) && r_is_read) begin
                if (r_grant == REQ_LOADER) begin
                    r_r1_rdata <= mem_rdata;
                end else begin
                    r_r0_rdata <= mem_rdata;
                end
            end
        end
    end

    // The ack is suppressed in a reset cycle so an aborted access never completes.
    assign w_resp    = (r_state == ST_RESP) && !reset;
    assign r0_ack    = w_resp && (r_grant == REQ_CORE);
    assign r1_ack    = w_resp && (r_grant == REQ_LOADER);
    assign r0_rdata  = (r0_ack && r_is_read) ? mem_rdata : r_r0_rdata;
    assign r1_rdata  = (r1_ack && r_is_read) ? mem_rdata : r_r1_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wmask = r_mem_wmask;
    assign mem_rstrb = r_mem_rstrb;
    assign oob_err   = r_oob;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed bench with a RAM, a transaction-level model and a
//               per-cycle compare against the arbiter outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int          ADDR_W     = 32;
    localparam int          MEM_WORDS  = 1024;
    localparam int          CORE_FIRST = 1;
    localparam logic [31:0] MEM_BYTES  = 32'(MEM_WORDS * 4);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ram_clear = 1'b1;
    logic        r0_req = 1'b0, r1_req = 1'b0;
    logic [31:0] r0_addr = '0, r0_wdata = '0, r1_addr = '0, r1_wdata = '0;
    logic [3:0]  r0_wmask = '0, r1_wmask = '0;
    logic [31:0] r0_rdata, r1_rdata;
    logic        r0_ack, r1_ack;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        oob_err;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .MEM_WORDS  (MEM_WORDS),
        .CORE_FIRST (CORE_FIRST)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .r0_req    (r0_req),
        .r0_addr   (r0_addr),
        .r0_wdata  (r0_wdata),
        .r0_wmask  (r0_wmask),
        .r0_rdata  (r0_rdata),
        .r0_ack    (r0_ack),
        .r1_req    (r1_req),
        .r1_addr   (r1_addr),
        .r1_wdata  (r1_wdata),
        .r1_wmask  (r1_wmask),
        .r1_rdata  (r1_rdata),
        .r1_ack    (r1_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .oob_err   (oob_err)
    );

    always #5 clk = ~clk;

    // Single-port RAM: byte-masked writes, registered read on strobe.
    logic [31:0] ram [0:MEM_WORDS-1];
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < MEM_WORDS; i++) ram[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (mem_rstrb) mem_rdata <= ram[mem_addr[11:2]];
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding access, ack two cycles after grant.
    logic        armed = 1'b0;
    longint      cyc = 0;
    int          last_w;
    logic        m_oob;
    logic [31:0] mmem [0:MEM_WORDS-1];
    logic [31:0] mrd [2];
    logic        t_v = 1'b0;
    int          t_who;
    logic [31:0] t_addr, t_wd, t_rd;
    logic [3:0]  t_wm;
    longint      t_ack;

    always @(posedge clk) begin
        int          w;
        logic [31:0] a;
        if (ram_clear) for (int i = 0; i < MEM_WORDS; i++) mmem[i] = '0;
        if (armed && t_v && cyc + 1 == t_ack && t_wm != 4'h0)
            for (int b = 0; b < 4; b++)
                if (t_wm[b]) mmem[t_addr[11:2]][8*b +: 8] = t_wd[8*b +: 8];
        if (reset) begin
            armed  = 1'b1;
            t_v    = 1'b0;
            m_oob  = 1'b0;
            last_w = (CORE_FIRST != 0) ? 1 : 0;
            mrd[0] = '0;
            mrd[1] = '0;
        end else if (armed) begin
            if (t_v && cyc == t_ack && t_wm == 4'h0) mrd[t_who] = t_rd;
            if ((!t_v || cyc > t_ack) && (r0_req || r1_req)) begin
                if (r0_req && r1_req) w = 1 - last_w;
                else                  w = r0_req ? 0 : 1;
                last_w = w;
                a = ((w == 1) ? r1_addr : r0_addr) & ~32'h3;
                if (a >= MEM_BYTES) m_oob = 1'b1;
                a      = a % MEM_BYTES;
                t_v    = 1'b1;
                t_who  = w;
                t_addr = a;
                t_wd   = (w == 1) ? r1_wdata : r0_wdata;
                t_wm   = (w == 1) ? r1_wmask : r0_wmask;
                t_rd   = mmem[a[11:2]];
                t_ack  = cyc + 2;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        logic in_resp, in_acc, e0, e1;
        if (armed) begin
            in_resp = t_v && (cyc == t_ack);
            in_acc  = t_v && (cyc + 1 == t_ack);
            e0 = in_resp && !reset && (t_who == 0);
            e1 = in_resp && !reset && (t_who == 1);
            chk("r0_ack", 32'(r0_ack), 32'(e0));
            chk("r1_ack", 32'(r1_ack), 32'(e1));
            chk("ack_exclusive", 32'(r0_ack & r1_ack), 32'h0);
            chk("r0_rdata", r0_rdata, (e0 && t_wm == 4'h0) ? t_rd : mrd[0]);
            chk("r1_rdata", r1_rdata, (e1 && t_wm == 4'h0) ? t_rd : mrd[1]);
            chk("mem_rstrb", 32'(mem_rstrb), 32'(in_acc && t_wm == 4'h0));
            chk("mem_wmask", 32'(mem_wmask), in_acc ? 32'(t_wm) : 32'h0);
            if (in_acc) chk("mem_addr", mem_addr, t_addr);
            if (in_acc && t_wm != 4'h0) chk("mem_wdata", mem_wdata, t_wd);
            chk("oob_err", 32'(oob_err), 32'(m_oob));
        end
    end

    // Issue one access and wait (bounded) for its ack; lat = -1 on timeout.
    task automatic access(input int who, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, output logic [31:0] rd, output int lat);
        if (who == 0) begin r0_req = 1'b1; r0_addr = a; r0_wdata = d; r0_wmask = m; end
        else          begin r1_req = 1'b1; r1_addr = a; r1_wdata = d; r1_wmask = m; end
        lat = -1;
        rd  = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if ((who == 0 && r0_ack) || (who == 1 && r1_ack)) begin
                lat = n;
                rd  = (who == 0) ? r0_rdata : r1_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        if (who == 0) r0_req = 1'b0; else r1_req = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        logic [11:0] a0pat, a1pat;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0; ram_clear = 1'b0;

        repeat (2) begin
            @(negedge clk);
            chk("idle_acks", 32'({r0_ack, r1_ack}), 32'h0);
            chk("idle_rstrb", 32'(mem_rstrb), 32'h0);
            chk("idle_wmask", 32'(mem_wmask), 32'h0);
            chk("idle_oob", 32'(oob_err), 32'h0);
        end
        @(posedge clk); #1;

        access(1, 32'h34, 32'hDEADBEEF, 4'hF, rd, lat);
        chk("r1_write_latency", 32'(lat), 32'd2);
        access(0, 32'h34, 32'h0, 4'h0, rd, lat);
        chk("r0_read_latency", 32'(lat), 32'd2);
        chk("r0_read_34", rd, 32'hDEADBEEF);

        access(1, 32'h2C, 32'h11223344, 4'hF, rd, lat);
        access(0, 32'h2C, 32'h000000AA, 4'b0001, rd, lat);
        chk("byte_write_latency", 32'(lat), 32'd2);
        access(0, 32'h2C, 32'h0, 4'h0, rd, lat);
        chk("byte_merge", rd, 32'h112233AA);
        access(1, 32'h34, 32'h0, 4'h0, rd, lat);
        chk("r1_read_34", rd, 32'hDEADBEEF);

        // Both held: loader was served last, so the core wins first.
        a0pat = '0; a1pat = '0;
        r0_req = 1'b1; r0_addr = 32'h34; r0_wmask = 4'h0;
        r1_req = 1'b1; r1_addr = 32'h2C; r1_wmask = 4'h0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            a0pat[n] = r0_ack;
            a1pat[n] = r1_ack;
        end
        @(posedge clk); #1;
        r0_req = 1'b0; r1_req = 1'b0;
        chk("contend_r0_acks", 32'(a0pat), 32'h104);
        chk("contend_r1_acks", 32'(a1pat), 32'h820);
        @(negedge clk);
        chk("contend_r0_data", r0_rdata, 32'hDEADBEEF);
        chk("contend_r1_data", r1_rdata, 32'h112233AA);
        @(posedge clk); #1;

        r0_req = 1'b1; r0_addr = 32'h1000; r0_wmask = 4'h0;
        @(negedge clk);
        @(negedge clk);
        chk("oob_mem_addr", mem_addr, 32'h0);
        chk("oob_rstrb", 32'(mem_rstrb), 32'h1);
        chk("oob_flag", 32'(oob_err), 32'h1);
        @(negedge clk);
        chk("oob_ack", 32'(r0_ack), 32'h1);
        chk("oob_rdata", r0_rdata, 32'h0);
        @(posedge clk); #1;
        r0_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("oob_sticky", 32'(oob_err), 32'h1);
        @(posedge clk); #1;

        r1_req = 1'b1; r1_addr = 32'h34; r1_wmask = 4'h0;
        @(posedge clk); #1;
        reset = 1'b1; r1_req = 1'b0;
        @(negedge clk);
        chk("abort_no_ack_access", 32'(r1_ack), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_no_ack_resp", 32'(r1_ack), 32'h0);
        chk("abort_rstrb", 32'(mem_rstrb), 32'h0);
        chk("oob_cleared", 32'(oob_err), 32'h0);
        @(posedge clk); #1;
        access(1, 32'h34, 32'h0, 4'h0, rd, lat);
        chk("fresh_latency", 32'(lat), 32'd2);
        chk("fresh_data", rd, 32'hDEADBEEF);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
